// File: rtl/input_pre_data_assembler_if.sv
// Row-assembler bus: byte stream in, padding/enable control, assembled row and PE launch strobe out.
interface input_pre_data_assembler_if;
   logic [7:0]  i_data_din;
   logic        i_data_din_vld;
   logic [7:0]  input_padding;
   logic        en;
   logic        PEclk;
   logic [0:271] parallel_data;

   modport master (
      output i_data_din,
      output i_data_din_vld,
      output input_padding,
      output en,
      input  PEclk,
      input  parallel_data
   );

   modport slave (
      input  i_data_din,
      input  i_data_din_vld,
      input  input_padding,
      input  en,
      output PEclk,
      output parallel_data
   );
endinterface

// File: rtl/input_pre_data_assembler.sv
// Serial-to-parallel row assembler: 34 byte slots with optional left/right zero pads, PEclk strobe per row.
// Optional build macro INPUT_PRE_DATA_DOUBLE_BUF_EN adds a separate output row register.
module input_pre_data_assembler (
   input  logic                       din_clk,
   input  logic                       rst_n,
   input_pre_data_assembler_if.slave  bus
);

   logic [5:0]   r_cnt;
   logic         r_padL;
   logic         r_padR;
   logic [0:271] r_asm;
   logic         r_peClk;

   logic         w_accept;
   logic         w_rowStart;
   logic         w_padL;
   logic         w_padR;
   logic [5:0]   w_rowLen;
   logic [5:0]   w_slot;
   logic         w_last;
   logic [0:271] w_asmNext;
   logic         w_unusedPadBits;

   assign w_accept        = bus.en & bus.i_data_din_vld;
   assign w_rowStart      = (r_cnt == 6'd0);
   assign w_unusedPadBits = ^bus.input_padding[6:1];

   // At row start the pads come straight from the input so the first byte sees them on the same edge.
   assign w_padL   = w_rowStart ? bus.input_padding[7] : r_padL;
   assign w_padR   = w_rowStart ? bus.input_padding[0] : r_padR;
   assign w_rowLen = 6'd34 - {5'd0, w_padL} - {5'd0, w_padR};
   assign w_slot   = r_cnt + {5'd0, w_padL};
   assign w_last   = (r_cnt == (w_rowLen - 6'd1));

   always_comb begin
      w_asmNext = r_asm;
      if (w_accept) begin
         // Pad slots are cleared when a row opens, since the previous row may have left data there.
         if (w_rowStart) begin
            if (w_padL) begin
               w_asmNext[0:7] = 8'h00;
            end
            if (w_padR) begin
               w_asmNext[264:271] = 8'h00;
            end
         end
         w_asmNext[{w_slot, 3'b000} +: 8] = bus.i_data_din;
      end
   end

   always_ff @(posedge din_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 6'd0;
         r_padL  <= 1'b0;
         r_padR  <= 1'b0;
         r_asm   <= '0;
         r_peClk <= 1'b0;
      end else begin
         r_peClk <= w_accept & w_last;
         if (bus.en) begin
            if (w_rowStart) begin
               r_padL <= bus.input_padding[7];
               r_padR <= bus.input_padding[0];
            end
            r_asm <= w_asmNext;
            if (w_accept) begin
               r_cnt <= w_last ? 6'd0 : (r_cnt + 6'd1);
            end
         end
      end
   end

   assign bus.PEclk = r_peClk;

`ifdef INPUT_PRE_DATA_DOUBLE_BUF_EN
   logic [0:271] r_out;

   always_ff @(posedge din_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
      end else if (w_accept && w_last) begin
         r_out <= w_asmNext;
      end
   end

   assign bus.parallel_data = r_out;
`else
   assign bus.parallel_data = r_asm;
`endif

endmodule

// File: tb/tb_input_pre_data_assembler.sv
// Self-checking bench for input_pre_data_assembler: table-driven rows, hand corner sequences, random traffic vs a queue model.
module tb_input_pre_data_assembler;

   logic din_clk;
   logic rst_n;

   input_pre_data_assembler_if bus ();

   input_pre_data_assembler dut (
      .din_clk (din_clk),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   initial din_clk = 1'b0;
   always #5 din_clk = ~din_clk;

   int total = 0;
   int bad   = 0;
   int cycle = 0;

   // Reference model: bytes of the open row, the pads latched for it, and the last completed row.
   logic [7:0]   rowQ[$];
   int           mL = 0;
   int           mR = 0;
   logic         expPe = 1'b0;
   logic [0:271] expRow = '0;
   logic [0:271] lastRow = '0;

   typedef struct {
      logic [7:0] pad;
      int         expN;
      logic [7:0] expSlot0;
      logic [7:0] expSlot33;
   } rowVec_t;

   rowVec_t vecs[6];

   function automatic logic [7:0] slotOf(input logic [0:271] v, input int k);
      return v[8*k +: 8];
   endfunction

   task automatic modelStep(input logic e, input logic v, input logic [7:0] d, input logic [7:0] p);
      expPe = 1'b0;
      if (e) begin
         if (rowQ.size() == 0) begin
            mL = int'(p[7]);
            mR = int'(p[0]);
         end
         if (v) begin
            rowQ.push_back(d);
            if (rowQ.size() == 34 - mL - mR) begin
               expRow = '0;
               foreach (rowQ[i]) expRow[8*(i+mL) +: 8] = rowQ[i];
               lastRow = expRow;
               expPe = 1'b1;
               rowQ.delete();
            end
         end
      end
   endtask

   task automatic checkOutput();
      total++;
      if (bus.PEclk !== expPe) begin
         bad++;
         $display("[TB] FAIL peclk cycle=%0d got=%b want=%b", cycle, bus.PEclk, expPe);
      end
      if (expPe) begin
         total++;
         if (bus.parallel_data !== expRow) begin
            bad++;
            $display("[TB] FAIL row cycle=%0d got=%h want=%h", cycle, bus.parallel_data, expRow);
         end
      end
`ifdef INPUT_PRE_DATA_DOUBLE_BUF_EN
      total++;
      if (bus.parallel_data !== lastRow) begin
         bad++;
         $display("[TB] FAIL hold cycle=%0d got=%h want=%h", cycle, bus.parallel_data, lastRow);
      end
`endif
   endtask

   task automatic applyStimulus(input logic e, input logic v, input logic [7:0] d, input logic [7:0] p);
      @(negedge din_clk);
      bus.en             = e;
      bus.i_data_din_vld = v;
      bus.i_data_din     = d;
      bus.input_padding  = p;
      @(posedge din_clk);
      modelStep(e, v, d, p);
      cycle++;
      #1;
      checkOutput();
   endtask

   task automatic doReset(input int n);
      @(negedge din_clk);
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.i_data_din_vld = 1'b0;
      rowQ.delete();
      expPe = 1'b0;
      lastRow = '0;
      for (int i = 0; i < n; i++) begin
         @(posedge din_clk);
         #1;
         total++;
         if (bus.PEclk !== 1'b0 || bus.parallel_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset got pe=%b row=%h want pe=0 row=0", bus.PEclk, bus.parallel_data);
         end
      end
      @(negedge din_clk);
      rst_n = 1'b1;
   endtask

   task automatic checkValue(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   int            sent;
   int            pulses;
   int            pulseCyc[$];
   logic [0:271]  capRow;

   initial begin
      vecs[0] = '{pad: 8'h81, expN: 32, expSlot0: 8'h00, expSlot33: 8'h00};
      vecs[1] = '{pad: 8'h00, expN: 34, expSlot0: 8'h01, expSlot33: 8'h22};
      vecs[2] = '{pad: 8'h80, expN: 33, expSlot0: 8'h00, expSlot33: 8'h21};
      vecs[3] = '{pad: 8'h01, expN: 33, expSlot0: 8'h01, expSlot33: 8'h00};
      vecs[4] = '{pad: 8'hFF, expN: 32, expSlot0: 8'h00, expSlot33: 8'h00};
      vecs[5] = '{pad: 8'h7E, expN: 34, expSlot0: 8'h01, expSlot33: 8'h22};

      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.i_data_din_vld = 1'b0;
      bus.i_data_din = 8'h00;
      bus.input_padding = 8'h00;
      doReset(100);

      $display("[TB] table-driven rows");
      for (int t = 0; t < 6; t++) begin
         sent = 0;
         capRow = '0;
         for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(i + 1), vecs[t].pad);
            sent++;
            if (bus.PEclk === 1'b1) begin
               capRow = bus.parallel_data;
               break;
            end
         end
         checkValue($sformatf("rowlen[%0d]", t), sent, vecs[t].expN);
         checkValue($sformatf("slot0[%0d]", t), int'(slotOf(capRow, 0)), int'(vecs[t].expSlot0));
         checkValue($sformatf("slot33[%0d]", t), int'(slotOf(capRow, 33)), int'(vecs[t].expSlot33));
         applyStimulus(1'b1, 1'b0, 8'h00, vecs[t].pad);
      end

      $display("[TB] enable stall mid-row");
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(i + 1), 8'h80);
         if (bus.PEclk === 1'b1) pulses++;
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 8'hEE, 8'h01);
         if (bus.PEclk === 1'b1) pulses++;
      end
      for (int i = 16; i < 32; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(i + 1), 8'h80);
         if (bus.PEclk === 1'b1) pulses++;
      end
      checkValue("stall early pulses", pulses, 0);
      applyStimulus(1'b1, 1'b1, 8'h21, 8'h80);
      checkValue("stall final pulse", int'(bus.PEclk), 1);
      checkValue("stall slot33", int'(slotOf(bus.parallel_data, 33)), 8'h21);

      $display("[TB] padding change mid-row ignored");
      sent = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(8'h40 + i), (i < 5) ? 8'h81 : 8'h00);
         sent++;
         if (bus.PEclk === 1'b1) break;
      end
      checkValue("midrow pad rowlen", sent, 32);

      $display("[TB] three back-to-back rows");
      pulseCyc.delete();
      for (int i = 0; i < 96; i++) begin
         applyStimulus(1'b1, 1'b1, 8'($urandom), 8'h81);
         if (bus.PEclk === 1'b1) pulseCyc.push_back(cycle);
      end
      checkValue("b2b pulse count", pulseCyc.size(), 3);
      if (pulseCyc.size() == 3) begin
         checkValue("b2b gap1", pulseCyc[1] - pulseCyc[0], 32);
         checkValue("b2b gap2", pulseCyc[2] - pulseCyc[1], 32);
      end

      $display("[TB] reset mid-row");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 8'h81);
      doReset(3);
      sent = 0;
      capRow = '0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b1, 8'(8'hA0 + i), 8'h81);
         sent++;
         if (bus.PEclk === 1'b1) begin
            capRow = bus.parallel_data;
            break;
         end
      end
      checkValue("post-reset rowlen", sent, 32);
      checkValue("post-reset slot1", int'(slotOf(capRow, 1)), 8'hA0);
      checkValue("post-reset slot32", int'(slotOf(capRow, 32)), 8'hBF);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                       8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h81);
      end

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_pre_data_assembler.md
# input_pre_data_assembler

Serial-to-parallel input staging block for the PE array. It accepts one 8-bit activation byte per cycle and assembles a 34-byte (272-bit) row window, inserting optional zero padding bytes at the left and right edges. When a row is complete it presents the row on `parallel_data` and pulses `PEclk` for one cycle to launch the PE array. It sits between the input data stream and the PE array row input.

## Interface
- No parameters; the row width is fixed at 34 byte slots (272 bits).
- `din_clk`  input  1  sole clock; all logic on rising edge.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `i_data_din`  input  8  input data byte.
- `i_data_din_vld`  input  1  `i_data_din` is valid this cycle.
- `input_padding`  input  8  padding control.
  - bit7: left pad enable.
  - bit0: right pad enable.
  - bits[6:1]: reserved, ignored.
- `en`  input  1  block enable; low stalls all state.
- `PEclk`  output  1  one-cycle row-ready strobe for the PE array; registered.
- `parallel_data`  output  [0:271]  assembled row; slot k is bits [8k:8k+7], and slot 0 is leftmost.

## Operation
- A byte is accepted on a `din_clk` edge when `en`=1 and `i_data_din_vld`=1.
- Padding latch:
  - At row start (byte counter = 0), the pad enables are taken from `input_padding[7]` and `input_padding[0]` on the same edge that accepts the first byte.
  - The latched value holds for the whole row; `input_padding` changes mid-row are ignored.
  - When no byte is accepted at row start, the latched value tracks `input_padding`.
- Row length N = 34 − L − R, where L and R are the latched left and right pad enables (N is 32, 33 or 34).
- Byte placement:
  - Accepted byte number i (0-based) is written to slot i+L.
  - Slot 0 is forced to 0x00 when L=1.
  - Slot 33 is forced to 0x00 when R=1.
- Byte counter: 6 bits; counts accepted bytes 0..N−1.
  - On accepting byte N−1 the row is complete, and the counter returns to 0 on that same edge.
  - The next accepted byte starts a new row, with no idle cycle required.
- `en`=0: no byte is accepted, and the counter, assembly register, output and latched pads hold. `PEclk` is driven 0.
- `i_data_din_vld`=0 with `en`=1: nothing is accepted and the state holds.

## Timing
- Reset (asynchronous, rst_n=0): counter=0, assembly register=0, `parallel_data`=0, `PEclk`=0, latched pads=0.
- Latency: on the edge that accepts the last byte of a row, the completed row (including that byte) appears on `parallel_data`. `PEclk`=1 during the following cycle only.
- `PEclk` is never high in two consecutive cycles unless rows complete in consecutive cycles, which is impossible because N≥32.
- Reset asserted mid-row discards the partial row; the next accepted byte after release is byte 0 of a new row.
- Simultaneous row completion and `input_padding` change: the new value applies to the next row only if it is still present at that row's first accepted byte.

## Configuration
- `INPUT_PRE_DATA_DOUBLE_BUF_EN` defined:
  - A separate 272-bit output register loads the complete row on the completion edge.
  - `parallel_data` stays stable for the whole of the next row's assembly.
- Not defined:
  - `parallel_data` is driven directly from the assembly register, so slots update live as bytes arrive.
  - Pad slots read 0x00.
  - The full row is valid during the `PEclk` cycle; contents after that cycle are unspecified.
- `PEclk` timing is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 100 cycles -> `parallel_data`=0, `PEclk`=0 throughout.
- Padding 8'b10000001, en=1, valid=1, bytes 0x01..0x20 -> after the 32nd byte, slot0=0x00, slots1..32=0x01..0x20, slot33=0x00, and `PEclk`=1 for exactly one cycle.
- Padding 8'h00, bytes 0x01..0x22 -> 34 bytes are consumed, slot k=k+1, and one `PEclk` pulse follows the 34th byte.
- Padding 8'h80, 33 bytes, then `en` toggled low for 5 cycles mid-row -> no bytes are lost, slot33 holds the 33rd byte, and `PEclk` pulses only after the 33rd accepted byte.
- Continuous valid for 3 rows with padding 8'h81 -> `PEclk` pulses every 32 cycles, and (double-buffer build) `parallel_data` changes only on the completion edges.
- Assert rst_n low after 10 bytes, release, then send 32 bytes -> the output row contains only the post-reset bytes.
